// File: rtl/hdmi_mode_ctrl_if.sv
// -----------------------------------------------------------------------------
// hdmi_mode_ctrl_if
// Link between the mode controller and the HDMI timing generator.
//   O_en                 : generator enable (controller -> generator)
//   I_busy               : generator busy   (generator -> controller)
//   O_h_total..O_v_res   : 12-bit timing set held stable for the whole frame
// Modports:
//   master : controller side (drives enable and timing, reads busy)
//   slave  : generator side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hdmi_mode_ctrl_if;
  logic        O_en;
  logic        I_busy;
  logic [11:0] O_h_total;
  logic [11:0] O_h_sync;
  logic [11:0] O_h_bporch;
  logic [11:0] O_h_res;
  logic [11:0] O_v_total;
  logic [11:0] O_v_sync;
  logic [11:0] O_v_bporch;
  logic [11:0] O_v_res;

  modport master (
    output O_en,
    output O_h_total, O_h_sync, O_h_bporch, O_h_res,
    output O_v_total, O_v_sync, O_v_bporch, O_v_res,
    input  I_busy
  );

  modport slave (
    input  O_en,
    input  O_h_total, O_h_sync, O_h_bporch, O_h_res,
    input  O_v_total, O_v_sync, O_v_bporch, O_v_res,
    output I_busy
  );
endinterface

// File: rtl/hdmi_mode_ctrl.sv
// -----------------------------------------------------------------------------
// hdmi_mode_ctrl
// Sequences the HDMI timing generator frame by frame and holds its timing set
// stable. Mode changes are queued as a pending request and applied only at a
// frame boundary, while the generator is idle.
//
// Build option: define MODE_1080P_EN to make mode 3 (1920x1080) valid; when it
// is undefined mode 3 requests are rejected and no 1080p entry exists.
//
// Ports:
//   I_pxl_clk, I_rst_n : pixel clock, asynchronous active-low reset
//   I_run              : level, keep generating frames
//   I_mode_req/_sel    : one-cycle request pulse carrying the wanted mode
//   gen                : generator link (enable, busy, timing set)
//   O_mode_cur         : mode currently loaded
//   O_mode_ack/_rej    : one-cycle pulses for a load / a rejected request
//   O_frame_start      : one-cycle pulse when the generator first shows busy
//   O_frame_cnt        : completed frames, wrapping
//   O_err              : sticky start-timeout flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hdmi_mode_ctrl #(
  parameter logic [7:0] START_TO = 8'd16
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_run,
  input  logic             I_mode_req,
  input  logic [1:0]       I_mode_sel,
  hdmi_mode_ctrl_if.master gen,
  output logic [1:0]       O_mode_cur,
  output logic             O_mode_ack,
  output logic             O_mode_rej,
  output logic             O_frame_start,
  output logic [15:0]      O_frame_cnt,
  output logic             O_err
);

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
  } timing_t;

  localparam timing_t MODE0_TIMING = '{
    h_total: 12'd1056, h_sync: 12'd128, h_bporch: 12'd88,  h_res: 12'd800,
    v_total: 12'd628,  v_sync: 12'd4,   v_bporch: 12'd23,  v_res: 12'd600
  };

  // Timing table lookup; unknown / disabled modes fall back to mode 0.
  function automatic timing_t mode_table(input logic [1:0] mode);
    timing_t t;
    case (mode)
      2'd1: t = '{h_total: 12'd1344, h_sync: 12'd136, h_bporch: 12'd160, h_res: 12'd1024,
                  v_total: 12'd806,  v_sync: 12'd6,   v_bporch: 12'd29,  v_res: 12'd768};
      2'd2: t = '{h_total: 12'd1650, h_sync: 12'd40,  h_bporch: 12'd220, h_res: 12'd1280,
                  v_total: 12'd750,  v_sync: 12'd5,   v_bporch: 12'd20,  v_res: 12'd720};
`ifdef MODE_1080P_EN
      2'd3: t = '{h_total: 12'd2200, h_sync: 12'd44,  h_bporch: 12'd148, h_res: 12'd1920,
                  v_total: 12'd1125, v_sync: 12'd5,   v_bporch: 12'd36,  v_res: 12'd1080};
`endif
      default: t = MODE0_TIMING;
    endcase
    return t;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [1:0]  pend_mode_q;
  logic        pend_vld_q;
  logic [7:0]  to_cnt_q;
  timing_t     timing_q;
  logic [1:0]  mode_cur_q;
  logic        en_q;
  logic        ack_q;
  logic        rej_q;
  logic        fs_q;
  logic        err_q;
  logic [15:0] frame_cnt_q;

  logic        req_valid_s;
  timing_t     tbl_d;

  // Request validity: mode 3 only exists when 1080p support is built in.
  always_comb begin
`ifdef MODE_1080P_EN
    req_valid_s = 1'b1;
`else
    if (I_mode_sel == 2'd3) begin
      req_valid_s = 1'b0;
    end else begin
      req_valid_s = 1'b1;
    end
`endif
  end

  // Timing set that S_LOAD would install for the pending mode.
  always_comb begin
    tbl_d = mode_table(pend_mode_q);
  end

  // Frame sequencer, request capture and all registered outputs.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= S_IDLE;
      pend_mode_q <= 2'd0;
      pend_vld_q  <= 1'b0;
      to_cnt_q    <= 8'd0;
      timing_q    <= MODE0_TIMING;
      mode_cur_q  <= 2'd0;
      en_q        <= 1'b0;
      ack_q       <= 1'b0;
      rej_q       <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      ack_q <= 1'b0;
      rej_q <= 1'b0;
      fs_q  <= 1'b0;

      // Last valid request wins; invalid requests leave pending state alone.
      if (I_mode_req) begin
        if (req_valid_s) begin
          pend_mode_q <= I_mode_sel;
          pend_vld_q  <= 1'b1;
        end else begin
          rej_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          en_q <= 1'b0;
          if (I_run) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (pend_vld_q) begin
            timing_q   <= tbl_d;
            mode_cur_q <= pend_mode_q;
            ack_q      <= 1'b1;
            // A request landing this very cycle must survive to the next boundary.
            if (!(I_mode_req && req_valid_s)) begin
              pend_vld_q <= 1'b0;
            end
          end
          to_cnt_q <= 8'd0;
          en_q     <= 1'b1;
          state_q  <= S_START;
        end
        S_START: begin
          if (gen.I_busy) begin
            en_q    <= 1'b0;
            fs_q    <= 1'b1;
            state_q <= S_RUN;
          end else if (to_cnt_q == (START_TO - 8'd1)) begin
            // Enable has now been high for START_TO cycles with no response.
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          if (!gen.I_busy) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          if (pend_vld_q && I_run) begin
            state_q <= S_LOAD;
          end else if (I_run) begin
            to_cnt_q <= 8'd0;
            en_q     <= 1'b1;
            state_q  <= S_START;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          en_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gen.O_en       = en_q;
  assign gen.O_h_total  = timing_q.h_total;
  assign gen.O_h_sync   = timing_q.h_sync;
  assign gen.O_h_bporch = timing_q.h_bporch;
  assign gen.O_h_res    = timing_q.h_res;
  assign gen.O_v_total  = timing_q.v_total;
  assign gen.O_v_sync   = timing_q.v_sync;
  assign gen.O_v_bporch = timing_q.v_bporch;
  assign gen.O_v_res    = timing_q.v_res;

  assign O_mode_cur    = mode_cur_q;
  assign O_mode_ack    = ack_q;
  assign O_mode_rej    = rej_q;
  assign O_frame_start = fs_q;
  assign O_frame_cnt   = frame_cnt_q;
  assign O_err         = err_q;

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
`timescale 1ns/1ps
module tb_hdmi_mode_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        mode_req = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic [1:0]  mode_cur;
  logic        ack, rej, fs, err;
  logic [15:0] fcnt;
  logic [95:0] tim_s;

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboards: timing set + mode expected at each ack, counts expected at each frame end.
  logic [95:0] tq[$];
  logic [1:0]  mq[$];
  logic [15:0] cq[$];

  // Generator model controls.
  int gen_on = 0;
  int frame_len = 8;
  bit arm = 1'b0;
  int rem = 0;

  hdmi_mode_ctrl_if gen_if();

  hdmi_mode_ctrl #(.START_TO(8'd16)) dut (
    .I_pxl_clk    (clk),
    .I_rst_n      (rst_n),
    .I_run        (run),
    .I_mode_req   (mode_req),
    .I_mode_sel   (mode_sel),
    .gen          (gen_if),
    .O_mode_cur   (mode_cur),
    .O_mode_ack   (ack),
    .O_mode_rej   (rej),
    .O_frame_start(fs),
    .O_frame_cnt  (fcnt),
    .O_err        (err)
  );

  always #5 clk = ~clk;

  assign tim_s = {gen_if.O_h_total, gen_if.O_h_sync, gen_if.O_h_bporch, gen_if.O_h_res,
                  gen_if.O_v_total, gen_if.O_v_sync, gen_if.O_v_bporch, gen_if.O_v_res};

  function automatic logic [95:0] exp_tim(input logic [1:0] m);
    case (m)
      2'd1:    return {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806,  12'd6, 12'd29, 12'd768};
      2'd2:    return {12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750,  12'd5, 12'd20, 12'd720};
      2'd3:    return {12'd2200, 12'd44,  12'd148, 12'd1920, 12'd1125, 12'd5, 12'd36, 12'd1080};
      default: return {12'd1056, 12'd128, 12'd88,  12'd800,  12'd628,  12'd4, 12'd23, 12'd600};
    endcase
  endfunction

  // Generator: samples enable, raises busy one cycle later for frame_len cycles.
  initial begin
    gen_if.I_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_on == 0) begin
        gen_if.I_busy = 1'b0;
        arm = 1'b0;
      end else if (gen_if.I_busy) begin
        if (rem <= 1) gen_if.I_busy = 1'b0;
        else rem = rem - 1;
      end else if (arm) begin
        gen_if.I_busy = 1'b1;
        rem = frame_len;
        arm = 1'b0;
      end else if (gen_if.O_en === 1'b1) begin
        arm = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mode_req = 1'b0; mode_sel = 2'd0; gen_on = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_busy(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (gen_if.I_busy === lvl) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fs === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (gen_if.O_en !== 1'b0) begin tests_failed++; $display("FAIL rst_en: got %b expected 0", gen_if.O_en); end
    tests_run++; if (tim_s !== exp_tim(2'd0)) begin tests_failed++; $display("FAIL rst_timing: got %h expected %h", tim_s, exp_tim(2'd0)); end
    tests_run++; if ({mode_cur, ack, rej, fs, err} !== 6'd0) begin tests_failed++; $display("FAIL rst_flags: got %b expected 000000", {mode_cur, ack, rej, fs, err}); end
    tests_run++; if (fcnt !== 16'd0) begin tests_failed++; $display("FAIL rst_fcnt: got %0h expected 0", fcnt); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_startup();
    bit ok;
    gen_on = 1; frame_len = 8; run = 1'b1;
    tick();
    tests_run++; if (gen_if.O_en !== 1'b0) begin tests_failed++; $display("FAIL start_en_n1: got %b expected 0", gen_if.O_en); end
    tick();
    tests_run++; if (gen_if.O_en !== 1'b1) begin tests_failed++; $display("FAIL start_en_n2: got %b expected 1", gen_if.O_en); end
    tick();
    tests_run++; if (fs !== 1'b0) begin tests_failed++; $display("FAIL start_fs_n3: got %b expected 0", fs); end
    tick();
    tests_run++; if (fs !== 1'b1) begin tests_failed++; $display("FAIL start_fs_n4: got %b expected 1", fs); end
    tick();
    tests_run++; if (fs !== 1'b0) begin tests_failed++; $display("FAIL start_fs_n5: got %b expected 0", fs); end
    tests_run++; if (tim_s !== exp_tim(2'd0) || mode_cur !== 2'd0) begin tests_failed++; $display("FAIL start_timing: got %h/%0d expected %h/0", tim_s, mode_cur, exp_tim(2'd0)); end
    cq.push_back(16'd1);
    wait_busy(1'b0, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL start_busy_fall: got timeout expected fall"); end
    tests_run++; if (fcnt !== cq[0]) begin tests_failed++; $display("FAIL start_fcnt: got %0h expected %0h", fcnt, cq[0]); end
    void'(cq.pop_front());
    tick();
    tests_run++; if (gen_if.O_en !== 1'b1) begin tests_failed++; $display("FAIL start_reen: got %b expected 1", gen_if.O_en); end
  endtask

  task automatic test_back_to_back();
    bit ok; int acks; int el;
    tq.delete(); mq.delete();
    wait_fs(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_fs: got timeout expected frame start"); end
    mode_req = 1'b1; mode_sel = 2'd1; tick();
    mode_sel = 2'd2; tick();
    mode_req = 1'b0;
    tq.push_back(exp_tim(2'd2)); mq.push_back(2'd2);
    wait_busy(1'b0, ok);
    tests_run++; if (tim_s !== exp_tim(2'd0)) begin tests_failed++; $display("FAIL b2b_hold: got %h expected %h", tim_s, exp_tim(2'd0)); end
    acks = 0; el = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) begin
          el = i;
          tests_run++; if (tim_s !== tq[0] || mode_cur !== mq[0]) begin tests_failed++; $display("FAIL b2b_load: got %h/%0d expected %h/%0d", tim_s, mode_cur, tq[0], mq[0]); end
          tests_run++; if (gen_if.O_en !== 1'b1) begin tests_failed++; $display("FAIL b2b_en_with_load: got %b expected 1", gen_if.O_en); end
          void'(tq.pop_front()); void'(mq.pop_front());
        end
      end
    end
    tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL b2b_ack_count: got %0d expected 1", acks); end
    tests_run++; if (el != 2) begin tests_failed++; $display("FAIL b2b_ack_latency: got %0d expected 2", el); end
  endtask

  task automatic test_mode_change();
    bit ok; bit moved; int acks;
    tq.delete(); mq.delete();
    wait_fs(ok);
    mode_req = 1'b1; mode_sel = 2'd1; tick();
    mode_req = 1'b0;
    tq.push_back(exp_tim(2'd1)); mq.push_back(2'd1);
    moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (gen_if.I_busy === 1'b0) break;
      if (tim_s !== exp_tim(2'd2)) moved = 1'b1;
      tick();
    end
    tests_run++; if (moved) begin tests_failed++; $display("FAIL mc_hold_midframe: got changed expected held"); end
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) begin
          tests_run++; if (tim_s !== tq[0] || mode_cur !== mq[0]) begin tests_failed++; $display("FAIL mc_load: got %h/%0d expected %h/%0d", tim_s, mode_cur, tq[0], mq[0]); end
          void'(tq.pop_front()); void'(mq.pop_front());
        end
      end
    end
    tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL mc_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_mode3();
    bit ok; int acks; logic exp_rej; logic [1:0] exp_mode;
`ifdef MODE_1080P_EN
    exp_rej = 1'b0; exp_mode = 2'd3;
`else
    exp_rej = 1'b1; exp_mode = 2'd1;
`endif
    wait_fs(ok);
    mode_req = 1'b1; mode_sel = 2'd3; tick();
    mode_req = 1'b0;
    tests_run++; if (rej !== exp_rej) begin tests_failed++; $display("FAIL m3_rej_pulse: got %b expected %b", rej, exp_rej); end
    tick();
    tests_run++; if (rej !== 1'b0) begin tests_failed++; $display("FAIL m3_rej_clear: got %b expected 0", rej); end
    wait_busy(1'b0, ok);
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    tests_run++; if (acks != int'(!exp_rej)) begin tests_failed++; $display("FAIL m3_ack_count: got %0d expected %0d", acks, int'(!exp_rej)); end
    tests_run++; if (tim_s !== exp_tim(exp_mode) || mode_cur !== exp_mode) begin tests_failed++; $display("FAIL m3_mode: got %h/%0d expected %h/%0d", tim_s, mode_cur, exp_tim(exp_mode), exp_mode); end
  endtask

  task automatic test_req_at_load();
    bit ok; bit seen;
    tq.delete(); mq.delete();
    wait_fs(ok);
    mode_req = 1'b1; mode_sel = 2'd2; tick();
    mode_req = 1'b0;
    tq.push_back(exp_tim(2'd2)); mq.push_back(2'd2);
    wait_busy(1'b0, ok);
    tick();
    mode_req = 1'b1; mode_sel = 2'd0;
    tq.push_back(exp_tim(2'd0)); mq.push_back(2'd0);
    tick();
    mode_req = 1'b0;
    tests_run++; if (ack !== 1'b1 || tim_s !== tq[0] || mode_cur !== mq[0]) begin tests_failed++; $display("FAIL ral_first: got %b/%h/%0d expected 1/%h/%0d", ack, tim_s, mode_cur, tq[0], mq[0]); end
    void'(tq.pop_front()); void'(mq.pop_front());
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack === 1'b1) begin seen = 1'b1; break; end
    end
    tests_run++; if (!seen || tim_s !== tq[0] || mode_cur !== mq[0]) begin tests_failed++; $display("FAIL ral_second: got %b/%h/%0d expected 1/%h/%0d", seen, tim_s, mode_cur, tq[0], mq[0]); end
    void'(tq.pop_front()); void'(mq.pop_front());
  endtask

  task automatic test_timeout();
    int en_ticks;
    do_reset();
    gen_on = 0; run = 1'b1;
    en_ticks = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i <= 18 && gen_if.O_en === 1'b1) en_ticks++;
      if (i == 17) begin
        tests_run++; if (err !== 1'b0 || gen_if.O_en !== 1'b1) begin tests_failed++; $display("FAIL to_before: got err=%b en=%b expected 0/1", err, gen_if.O_en); end
      end
      if (i == 18) begin
        tests_run++; if (err !== 1'b1 || gen_if.O_en !== 1'b0) begin tests_failed++; $display("FAIL to_expire: got err=%b en=%b expected 1/0", err, gen_if.O_en); end
      end
      if (i == 20) begin
        tests_run++; if (gen_if.O_en !== 1'b1 || err !== 1'b1) begin tests_failed++; $display("FAIL to_restart: got en=%b err=%b expected 1/1", gen_if.O_en, err); end
      end
    end
    tests_run++; if (en_ticks != 16) begin tests_failed++; $display("FAIL to_en_cycles: got %0d expected 16", en_ticks); end
    run = 1'b0;
    repeat (40) tick();
    tests_run++; if (gen_if.O_en !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("FAIL to_idle: got en=%b err=%b expected 0/1", gen_if.O_en, err); end
  endtask

  task automatic test_stop_wrap();
    bit ok; int en_ticks;
    do_reset();
    gen_on = 1; run = 1'b1;
    wait_fs(ok);
    run = 1'b0;
    cq.push_back(16'd1);
    wait_busy(1'b0, ok);
    tests_run++; if (!ok || fcnt !== cq[0]) begin tests_failed++; $display("FAIL stop_fcnt: got %0h expected %0h", fcnt, cq[0]); end
    void'(cq.pop_front());
    en_ticks = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gen_if.O_en === 1'b1) en_ticks++;
    end
    tests_run++; if (en_ticks != 0) begin tests_failed++; $display("FAIL stop_no_en: got %0d expected 0", en_ticks); end
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    cq.push_back(16'hFFFF + 16'd1);
    run = 1'b1;
    wait_fs(ok);
    run = 1'b0;
    wait_busy(1'b0, ok);
    tests_run++; if (!ok || fcnt !== cq[0]) begin tests_failed++; $display("FAIL wrap_fcnt: got %0h expected %0h", fcnt, cq[0]); end
    void'(cq.pop_front());
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    gen_on = 1; run = 1'b1;
    wait_fs(ok);
    wait_busy(1'b0, ok);
    tick();
    tests_run++; if (gen_if.O_en !== 1'b1 || fcnt !== 16'd1) begin tests_failed++; $display("FAIL ares_pre: got en=%b cnt=%0h expected 1/1", gen_if.O_en, fcnt); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (gen_if.O_en !== 1'b0 || fcnt !== 16'd0 || tim_s !== exp_tim(2'd0)) begin tests_failed++; $display("FAIL ares_now: got en=%b cnt=%0h expected 0/0", gen_if.O_en, fcnt); end
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_back_to_back();
    test_mode_change();
    test_mode3();
    test_req_at_load();
    test_timeout();
    test_stop_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
